tcp_conn_fsm_multi: RTL and testbench

- Parametrised multi-connection TCP handshake controller; next generation of the single-connection CLOSED/LISTEN/SYN_RCVD/ESTABLISHED control FSM.
- Tracks NUM_CONN independent connection state machines and accepts one event per cycle over a valid/ready port.
- Emits control-segment requests (SYN/ACK/RST flags) through a single registered tx slot.
- Adds behaviour the single-connection version lacks: passive open, SYN_SENT with simultaneous open, handshake timeout, timed FLUSH drain, and event-drop reporting.

---
 rtl/tcp_conn_fsm_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_tcp_conn_fsm_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_conn_fsm_multi.sv
// Multi-connection TCP handshake controller: NUM_CONN connection FSMs sharing one
// valid/ready event port and one registered control-segment tx slot.
module tcp_conn_fsm_multi #(
    parameter int unsigned NUM_CONN       = 4,
    parameter int unsigned ID_W           = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned FLUSH_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic [ID_W-1:0]       evt_conn_id,
    input  logic [2:0]            evt_type,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ID_W-1:0]       tx_conn_id,
    output logic [2:0]            tx_flags,
    output logic [4*NUM_CONN-1:0] state_o,
    output logic                  evt_drop
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [3:0] {
        S_CLOSED   = 4'd0, S_LISTEN   = 4'd1, S_RST_RCVD = 4'd2, S_FLUSH = 4'd3,
        S_SYN_RCVD = 4'd4, S_SYN_SENT = 4'd5, S_ESTAB    = 4'd6
    } conn_state_e;

    localparam logic [2:0] EV_ACTIVE_OPEN  = 3'd0;
    localparam logic [2:0] EV_PASSIVE_OPEN = 3'd1;
    localparam logic [2:0] EV_SYN          = 3'd2;
    localparam logic [2:0] EV_SYN_ACK      = 3'd3;
    localparam logic [2:0] EV_ACK          = 3'd4;
    localparam logic [2:0] EV_RST          = 3'd5;
    localparam logic [2:0] EV_CLOSE        = 3'd6;

    localparam logic [2:0] F_NONE   = 3'b000;
    localparam logic [2:0] F_ACK    = 3'b001;
    localparam logic [2:0] F_SYN    = 3'b010;
    localparam logic [2:0] F_SYNACK = 3'b011;
    localparam logic [2:0] F_RST    = 3'b100;

    conn_state_e      r_state   [NUM_CONN];
    logic [TMO_W-1:0] r_tmo     [NUM_CONN];
    logic [FL_W-1:0]  r_fl      [NUM_CONN];
    logic             r_tx_valid;
    logic [ID_W-1:0]  r_tx_conn_id;
    logic [2:0]       r_tx_flags;
    logic             r_evt_drop;

    conn_state_e      w_state_nxt [NUM_CONN];
    logic [TMO_W-1:0] w_tmo_nxt   [NUM_CONN];
    logic [FL_W-1:0]  w_fl_nxt    [NUM_CONN];
    conn_state_e      w_cur;
    conn_state_e      w_evt_nxt;
    logic [2:0]       w_evt_flg;
    logic             w_id_ok;
    logic             w_legal;
    logic             w_slot_free;
    logic             w_exp_any;
    logic [ID_W-1:0]  w_exp_id;
    logic             w_serve_exp;
    logic             w_accept;
    logic             w_tx_valid_nxt;
    logic [ID_W-1:0]  w_tx_id_nxt;
    logic [2:0]       w_tx_flags_nxt;
    logic             w_drop_nxt;

    // Transition table lookup for the targeted connection
    always_comb begin
        w_cur   = S_CLOSED;
        w_id_ok = 1'b0;
        for (int i = 0; i < int'(NUM_CONN); i++) begin
            if (evt_conn_id == ID_W'(i)) begin
                w_cur   = r_state[i];
                w_id_ok = 1'b1;
            end
        end
        w_legal   = 1'b0;
        w_evt_nxt = w_cur;
        w_evt_flg = F_NONE;
        if (w_id_ok) begin
            case (w_cur)
                S_CLOSED: case (evt_type)
                    EV_ACTIVE_OPEN:  begin w_legal = 1'b1; w_evt_nxt = S_SYN_SENT; w_evt_flg = F_SYN; end
                    EV_PASSIVE_OPEN: begin w_legal = 1'b1; w_evt_nxt = S_LISTEN; end
                    EV_SYN:          begin w_legal = 1'b1; w_evt_nxt = S_CLOSED; w_evt_flg = F_RST; end
                    EV_RST:          begin w_legal = 1'b1; w_evt_nxt = S_CLOSED; end
                    default: ;
                endcase
                S_LISTEN: case (evt_type)
                    EV_SYN:   begin w_legal = 1'b1; w_evt_nxt = S_SYN_RCVD; w_evt_flg = F_SYNACK; end
                    EV_CLOSE: begin w_legal = 1'b1; w_evt_nxt = S_CLOSED; end
                    EV_RST:   begin w_legal = 1'b1; w_evt_nxt = S_LISTEN; end
                    default: ;
                endcase
                S_SYN_SENT: case (evt_type)
                    EV_SYN_ACK: begin w_legal = 1'b1; w_evt_nxt = S_ESTAB; w_evt_flg = F_ACK; end
                    EV_SYN:     begin w_legal = 1'b1; w_evt_nxt = S_SYN_RCVD; w_evt_flg = F_SYNACK; end
                    EV_RST:     begin w_legal = 1'b1; w_evt_nxt = S_RST_RCVD; end
                    EV_CLOSE:   begin w_legal = 1'b1; w_evt_nxt = S_CLOSED; end
                    default: ;
                endcase
                S_SYN_RCVD: case (evt_type)
                    EV_ACK:   begin w_legal = 1'b1; w_evt_nxt = S_ESTAB; end
                    EV_RST:   begin w_legal = 1'b1; w_evt_nxt = S_RST_RCVD; end
                    EV_CLOSE: begin w_legal = 1'b1; w_evt_nxt = S_FLUSH; end
                    default: ;
                endcase
                S_ESTAB: case (evt_type)
                    EV_RST:   begin w_legal = 1'b1; w_evt_nxt = S_RST_RCVD; end
                    EV_CLOSE: begin w_legal = 1'b1; w_evt_nxt = S_FLUSH; end
                    EV_ACK:   begin w_legal = 1'b1; w_evt_nxt = S_ESTAB; end
                    default: ;
                endcase
                S_FLUSH: begin
                    if (evt_type == EV_RST) begin
                        w_legal   = 1'b1;
                        w_evt_nxt = S_RST_RCVD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Expiry arbitration (lowest id wins) and the shared ready rule
    always_comb begin
        w_exp_any = 1'b0;
        w_exp_id  = '0;
        for (int i = 0; i < int'(NUM_CONN); i++) begin
            if (!w_exp_any && (r_state[i] == S_SYN_SENT || r_state[i] == S_SYN_RCVD)
                && r_tmo[i] == TMO_LAST) begin
                w_exp_any = 1'b1;
                w_exp_id  = ID_W'(i);
            end
        end
        w_slot_free = ~r_tx_valid | tx_ready;
        w_serve_exp = w_slot_free & w_exp_any;
        evt_ready   = w_slot_free & ~w_exp_any;
        w_accept    = evt_valid & evt_ready;
    end

    // Per-connection next state: autonomous progress, then expiry, then the event
    always_comb begin
        for (int i = 0; i < int'(NUM_CONN); i++) begin
            w_state_nxt[i] = r_state[i];
            w_tmo_nxt[i]   = r_tmo[i];
            w_fl_nxt[i]    = r_fl[i];
            case (r_state[i])
                S_SYN_SENT, S_SYN_RCVD: begin
                    if (r_tmo[i] != TMO_LAST) w_tmo_nxt[i] = r_tmo[i] + TMO_W'(1);
                end
                S_FLUSH: begin
                    if (r_fl[i] == FL_LAST) w_state_nxt[i] = S_CLOSED;
                    else                    w_fl_nxt[i]    = r_fl[i] + FL_W'(1);
                end
                S_RST_RCVD: w_state_nxt[i] = S_CLOSED;
                default: ;
            endcase
            if (w_serve_exp && w_exp_id == ID_W'(i)) w_state_nxt[i] = S_CLOSED;
            if (w_accept && w_legal && evt_conn_id == ID_W'(i)) begin
                w_state_nxt[i] = w_evt_nxt;
                if (w_evt_nxt == S_SYN_SENT || w_evt_nxt == S_SYN_RCVD) w_tmo_nxt[i] = '0;
                if (w_evt_nxt == S_FLUSH) w_fl_nxt[i] = '0;
            end
        end
    end

    // Tx slot: timeout RST has priority over event-driven segments
    always_comb begin
        w_tx_valid_nxt = r_tx_valid;
        w_tx_id_nxt    = r_tx_conn_id;
        w_tx_flags_nxt = r_tx_flags;
        if (w_serve_exp) begin
            w_tx_valid_nxt = 1'b1;
            w_tx_id_nxt    = w_exp_id;
            w_tx_flags_nxt = F_RST;
        end else if (w_accept && w_legal && w_evt_flg != F_NONE) begin
            w_tx_valid_nxt = 1'b1;
            w_tx_id_nxt    = evt_conn_id;
            w_tx_flags_nxt = w_evt_flg;
        end else if (tx_ready) begin
            w_tx_valid_nxt = 1'b0;
        end
        w_drop_nxt = w_accept & ~w_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CONN); i++) begin
                r_state[i] <= S_CLOSED;
                r_tmo[i]   <= '0;
                r_fl[i]    <= '0;
            end
            r_tx_valid   <= 1'b0;
            r_tx_conn_id <= '0;
            r_tx_flags   <= '0;
            r_evt_drop   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CONN); i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tmo[i]   <= w_tmo_nxt[i];
                r_fl[i]    <= w_fl_nxt[i];
            end
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_conn_id <= w_tx_id_nxt;
            r_tx_flags   <= w_tx_flags_nxt;
            r_evt_drop   <= w_drop_nxt;
        end
    end

    for (genvar g = 0; g < int'(NUM_CONN); g++) begin : g_state
        assign state_o[4*g +: 4] = r_state[g];
    end

    assign tx_valid   = r_tx_valid;
    assign tx_conn_id = r_tx_conn_id;
    assign tx_flags   = r_tx_flags;
    assign evt_drop   = r_evt_drop;

endmodule

// File: tb/tb_tcp_conn_fsm_multi.sv
// Bench for tcp_conn_fsm_multi: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a transition-table reference model.
`timescale 1ns/1ps
module tb_tcp_conn_fsm_multi;
    localparam int NC  = 5;
    localparam int IW  = 3;
    localparam int TMO = 8;
    localparam int FLC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_conn_id;
    logic [2:0]    evt_type;
    logic          tx_valid;
    logic          tx_ready;
    logic [IW-1:0] tx_conn_id;
    logic [2:0]    tx_flags;
    logic [4*NC-1:0] state_o;
    logic          evt_drop;

    tcp_conn_fsm_multi #(
        .NUM_CONN(NC), .ID_W(IW), .TIMEOUT_CYCLES(TMO), .FLUSH_CYCLES(FLC)
    ) dut (
        .clk(clk), .rst(rst),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_conn_id(evt_conn_id), .evt_type(evt_type),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_conn_id(tx_conn_id), .tx_flags(tx_flags),
        .state_o(state_o), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    // Reference model: state per conn, cycles spent in the current state, tx slot
    int m_state [NC];
    int m_age   [NC];
    bit m_txv;
    int m_txid;
    int m_txfl;
    bit m_drop;
    int tbl [7][8];   // next_state*8 + flags, or -1 when the event is illegal

    int n_checks = 0;
    int n_err    = 0;
    bit s_ready;

    typedef struct {
        bit v; int id; int ty; bit txr;
        int conn; int st; bit txv; int fl; bit drop;
    } vec_t;
    vec_t vecs [12];

    function automatic void chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_state[i] = 0;
            m_age[i]   = 0;
        end
        m_txv = 1'b0; m_txid = 0; m_txfl = 0; m_drop = 1'b0;
    endfunction

    function automatic bit expired(input int i);
        return (m_state[i] == 4 || m_state[i] == 5) && m_age[i] >= TMO - 1;
    endfunction

    function automatic bit model_ready(input bit txr);
        if (m_txv && !txr) return 1'b0;
        for (int i = 0; i < NC; i++) if (expired(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_advance(input bit v, input int id, input int ty, input bit txr);
        int nst [NC];
        bit free;
        bit acc;
        int exp_id;
        int ent;
        free   = !m_txv || txr;
        acc    = v && model_ready(txr);
        exp_id = -1;
        for (int i = NC - 1; i >= 0; i--) if (expired(i)) exp_id = i;
        ent = -1;
        if (acc && id < NC) ent = tbl[m_state[id]][ty];
        for (int i = 0; i < NC; i++) begin
            nst[i] = m_state[i];
            if (m_state[i] == 2) nst[i] = 0;
            if (m_state[i] == 3 && m_age[i] == FLC - 1) nst[i] = 0;
        end
        m_drop = acc && ent < 0;
        if (free && exp_id >= 0) begin
            nst[exp_id] = 0;
            m_txv = 1'b1; m_txid = exp_id; m_txfl = 4;
        end else if (acc && ent >= 0 && ent % 8 != 0) begin
            m_txv = 1'b1; m_txid = id; m_txfl = ent % 8;
        end else if (txr) begin
            m_txv = 1'b0;
        end
        if (acc && ent >= 0) nst[id] = ent / 8;
        for (int i = 0; i < NC; i++) begin
            if (nst[i] != m_state[i] || (acc && ent >= 0 && i == id)) m_age[i] = 0;
            else m_age[i] = m_age[i] + 1;
            m_state[i] = nst[i];
        end
    endfunction

    function automatic void check_outputs(input bit txr);
        logic [4*NC-1:0] want;
        for (int i = 0; i < NC; i++) want[4*i +: 4] = 4'(m_state[i]);
        chk("state_o", int'(state_o), int'(want));
        chk("evt_ready", int'(evt_ready), int'(model_ready(txr)));
        chk("tx_valid", int'(tx_valid), int'(m_txv));
        if (m_txv) begin
            chk("tx_conn_id", int'(tx_conn_id), m_txid);
            chk("tx_flags", int'(tx_flags), m_txfl);
        end
        chk("evt_drop", int'(evt_drop), int'(m_drop));
    endfunction

    // One clock: drive at posedge+1, check/advance model at negedge
    task automatic step(input bit v, input int id, input int ty, input bit txr);
        evt_valid   = v;
        evt_conn_id = IW'(id);
        evt_type    = 3'(ty);
        tx_ready    = txr;
        @(negedge clk);
        s_ready = evt_ready;
        check_outputs(txr);
        model_advance(v, id, ty, txr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit rdy_at_exp;

        for (int s = 0; s < 7; s++) for (int t = 0; t < 8; t++) tbl[s][t] = -1;
        tbl[0][0] = 5*8 + 2; tbl[0][1] = 1*8;     tbl[0][2] = 0*8 + 4; tbl[0][5] = 0;
        tbl[1][2] = 4*8 + 3; tbl[1][6] = 0;       tbl[1][5] = 1*8;
        tbl[5][3] = 6*8 + 1; tbl[5][2] = 4*8 + 3; tbl[5][5] = 2*8;     tbl[5][6] = 0;
        tbl[4][4] = 6*8;     tbl[4][5] = 2*8;     tbl[4][6] = 3*8;
        tbl[6][5] = 2*8;     tbl[6][6] = 3*8;     tbl[6][4] = 6*8;
        tbl[3][5] = 2*8;

        //           v  id ty txr conn st txv fl drop
        vecs[0]  = '{1, 0, 0, 1,  0,  5, 1,  2, 0};
        vecs[1]  = '{1, 0, 3, 1,  0,  6, 1,  1, 0};
        vecs[2]  = '{1, 2, 1, 1,  2,  1, 0,  0, 0};
        vecs[3]  = '{1, 2, 2, 1,  2,  4, 1,  3, 0};
        vecs[4]  = '{1, 2, 4, 1,  2,  6, 0,  0, 0};
        vecs[5]  = '{1, 1, 4, 1,  1,  0, 0,  0, 1};
        vecs[6]  = '{1, 1, 7, 1,  1,  0, 0,  0, 1};
        vecs[7]  = '{1, 6, 0, 1,  0,  6, 0,  0, 1};
        vecs[8]  = '{1, 4, 5, 1,  4,  0, 0,  0, 0};
        vecs[9]  = '{1, 3, 0, 1,  3,  5, 1,  2, 0};
        vecs[10] = '{1, 3, 3, 1,  3,  6, 1,  1, 0};
        vecs[11] = '{1, 3, 6, 1,  3,  3, 0,  0, 0};

        rst = 1'b1; evt_valid = 1'b0; evt_conn_id = '0; evt_type = '0; tx_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset state_o", int'(state_o), 0);
        chk("reset tx_valid", int'(tx_valid), 0);
        chk("reset tx_conn_id", int'(tx_conn_id), 0);
        chk("reset tx_flags", int'(tx_flags), 0);
        chk("reset evt_drop", int'(evt_drop), 0);
        repeat (2) step(0, 0, 0, 1);

        for (int k = 0; k < 12; k++) begin
            step(vecs[k].v, vecs[k].id, vecs[k].ty, vecs[k].txr);
            chk($sformatf("vec%0d state", k), int'(state_o[4*vecs[k].conn +: 4]), vecs[k].st);
            chk($sformatf("vec%0d tx_valid", k), int'(tx_valid), int'(vecs[k].txv));
            if (vecs[k].txv) chk($sformatf("vec%0d tx_flags", k), int'(tx_flags), vecs[k].fl);
            chk($sformatf("vec%0d drop", k), int'(evt_drop), int'(vecs[k].drop));
        end

        // FLUSH dwell on conn 3, then RST inside FLUSH
        cnt = 1;
        for (int k = 0; k < 20 && state_o[15:12] == 4'd3; k++) begin
            step(0, 0, 0, 1);
            if (state_o[15:12] == 4'd3) cnt++;
        end
        chk("flush dwell", cnt, FLC);
        chk("flush end state", int'(state_o[15:12]), 0);
        step(1, 3, 0, 1);
        step(1, 3, 3, 1);
        step(1, 3, 6, 1);
        step(1, 3, 5, 1);
        chk("rst in flush", int'(state_o[15:12]), 2);
        step(0, 0, 0, 1);
        chk("rst_rcvd to closed", int'(state_o[15:12]), 0);

        // Handshake timeout on conn 1
        step(1, 1, 0, 1);
        cnt = 1;
        rdy_at_exp = 1'b1;
        for (int k = 0; k < 20 && state_o[7:4] == 4'd5; k++) begin
            step(0, 0, 0, 1);
            if (state_o[7:4] == 4'd5) cnt++;
            else rdy_at_exp = s_ready;
        end
        chk("timeout dwell", cnt, TMO);
        chk("timeout ready low", int'(rdy_at_exp), 0);
        chk("timeout tx_valid", int'(tx_valid), 1);
        chk("timeout tx_conn_id", int'(tx_conn_id), 1);
        chk("timeout tx_flags", int'(tx_flags), 4);

        // Backpressure: SYN held for conn 4 while its timeout expires
        step(1, 4, 0, 1);
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 4, 0);
            chk("bp ready", int'(s_ready), 0);
            chk("bp tx_valid", int'(tx_valid), 1);
            chk("bp tx_conn_id", int'(tx_conn_id), 4);
            chk("bp tx_flags", int'(tx_flags), 2);
            chk("bp state", int'(state_o[19:16]), 5);
        end
        step(1, 0, 4, 1);
        chk("bp release ready", int'(s_ready), 0);
        chk("bp rst tx_conn_id", int'(tx_conn_id), 4);
        chk("bp rst tx_flags", int'(tx_flags), 4);
        chk("bp rst state", int'(state_o[19:16]), 0);
        chk("bp no drop", int'(evt_drop), 0);
        step(0, 0, 0, 1);

        // Asynchronous reset in the middle of SYN_SENT
        step(1, 1, 0, 1);
        evt_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state_o", int'(state_o), 0);
        chk("async rst tx_valid", int'(tx_valid), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
